cronometro_bcd_param: RTL and testbench

Parametrised nine-digit BCD stopwatch/timer and next-generation stopwatch core of the display subsystem. It counts hh:mm:ss.mcd from a prescaled base tick and supports up and down (countdown) modes, pause/resume, preset load and lap capture. Its packed BCD outputs feed the seven-segment decoders directly.

---
 rtl/cronometro_bcd_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cronometro_bcd_param.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_bcd_param.sv
// cronometro_bcd_param
//
// Nine-digit BCD stopwatch / countdown timer (hh:mm:ss.mcd). A prescaler
// divides the system clock into base ticks. On each base tick the time
// steps up or down by one millisecond with BCD carry or borrow. The core
// also supports pause/resume, a clamped preset load and lap capture.
//
// Ports
//   clk_i          system clock, rising edge active
//   rst_i          synchronous active-high reset
//   play_i         level; rising edge starts from idle or toggles run/pause
//   stop_i         level; clears the count and returns to idle
//   lap_i          level; captures the current time every cycle in run/pause
//   load_i         loads the clamped preset while idle
//   down_i         0 = count up, 1 = count down (sampled only when starting)
//   preset_bcd_i   preset value, same packing as time_bcd_o
//   time_bcd_o     current time {hT,hU,mT,mU,sT,sU,ds,cs,ms}, 4 bits each
//   lap_bcd_o      last captured time
//   lap_strobe_o   one-cycle pulse per capture
//   running_o      high while in RUN
//   wrap_o         one-cycle pulse on up-mode rollover to zero
//   done_o         one-cycle pulse when a countdown reaches zero

module cronometro_bcd_param #(
    parameter int DIV      = 50000,
    parameter int HOUR_MAX = 99
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        play_i,
    input  logic        stop_i,
    input  logic        lap_i,
    input  logic        load_i,
    input  logic        down_i,
    input  logic [35:0] preset_bcd_i,
    output logic [35:0] time_bcd_o,
    output logic [35:0] lap_bcd_o,
    output logic        lap_strobe_o,
    output logic        running_o,
    output logic        wrap_o,
    output logic        done_o
);

    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]    HOUR_TENS  = 4'(HOUR_MAX / 10);
    localparam logic [3:0]    HOUR_UNITS = 4'(HOUR_MAX % 10);
    localparam logic [6:0]    HOUR_LIMIT = 7'(HOUR_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [35:0]   timeBcd_q, timeBcd_d;
    logic [35:0]   lapBcd_q, lapBcd_d;
    logic          lapStrobe_q, lapStrobe_d;
    logic          running_q;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;
    logic          playPrev_q;

    logic          playRise;
    logic          tick;
    logic [35:0]   timeInc;
    logic [35:0]   timeDec;
    logic [35:0]   presetClamped;
    logic          incCarry;
    logic          incWrap;
    logic          decBorrow;
    logic          decZero;
    logic [3:0]    hourTens;
    logic [3:0]    hourUnits;
    logic [6:0]    hourValue;

    // Digits 0..6 are ms, cs, ds, sU, sT, mU, mT; the two tens digits stop at 5.
    function automatic logic [3:0] digitMax(input int idx);
        return (idx == 4 || idx == 6) ? 4'd5 : 4'd9;
    endfunction

    assign playRise = play_i & ~playPrev_q;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

    // Up-count by one millisecond. The carry ripples through the sub-hour
    // digits; the hours are handled as a whole value so that HOUR_MAX
    // does not have to be a multiple of ten.
    always_comb begin
        timeInc  = timeBcd_q;
        incCarry = 1'b1;
        incWrap  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (incCarry) begin
                if (timeBcd_q[i*4 +: 4] >= digitMax(i)) begin
                    timeInc[i*4 +: 4] = 4'd0;
                end else begin
                    timeInc[i*4 +: 4] = timeBcd_q[i*4 +: 4] + 4'd1;
                    incCarry          = 1'b0;
                end
            end
        end
        if (incCarry) begin
            if (timeBcd_q[35:28] == {HOUR_TENS, HOUR_UNITS}) begin
                timeInc = '0;
                incWrap = 1'b1;
            end else if (timeBcd_q[31:28] >= 4'd9) begin
                timeInc[31:28] = 4'd0;
                timeInc[35:32] = timeBcd_q[35:32] + 4'd1;
            end else begin
                timeInc[31:28] = timeBcd_q[31:28] + 4'd1;
            end
        end
    end

    // Down-count by one millisecond. A countdown never runs while the time
    // is zero, so the hours never underflow.
    always_comb begin
        timeDec   = timeBcd_q;
        decBorrow = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (decBorrow) begin
                if (timeBcd_q[i*4 +: 4] == 4'd0) begin
                    timeDec[i*4 +: 4] = digitMax(i);
                end else begin
                    timeDec[i*4 +: 4] = timeBcd_q[i*4 +: 4] - 4'd1;
                    decBorrow         = 1'b0;
                end
            end
        end
        if (decBorrow) begin
            if (timeBcd_q[31:28] == 4'd0) begin
                timeDec[31:28] = 4'd9;
                timeDec[35:32] = timeBcd_q[35:32] - 4'd1;
            end else begin
                timeDec[31:28] = timeBcd_q[31:28] - 4'd1;
            end
        end
        decZero = (timeDec == 36'd0);
    end

    // Preset clamp: saturate every digit to its own range. Then limit the
    // hour value (after the per-digit saturation) to HOUR_MAX.
    always_comb begin
        presetClamped = '0;
        for (int i = 0; i < 7; i++) begin
            if (preset_bcd_i[i*4 +: 4] > digitMax(i)) begin
                presetClamped[i*4 +: 4] = digitMax(i);
            end else begin
                presetClamped[i*4 +: 4] = preset_bcd_i[i*4 +: 4];
            end
        end
        hourTens  = (preset_bcd_i[35:32] > 4'd9) ? 4'd9 : preset_bcd_i[35:32];
        hourUnits = (preset_bcd_i[31:28] > 4'd9) ? 4'd9 : preset_bcd_i[31:28];
        hourValue = {3'd0, hourTens} * 7'd10 + {3'd0, hourUnits};
        if (hourValue > HOUR_LIMIT) begin
            presetClamped[35:28] = {HOUR_TENS, HOUR_UNITS};
        end else begin
            presetClamped[35:28] = {hourTens, hourUnits};
        end
    end

    // Next-state logic. Stop overrides everything below it. Within a state,
    // a play edge takes precedence over the tick, so the pause edge leaves
    // the prescaler phase where it was. Lap capture samples the time as it
    // stands before this edge's update.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        timeBcd_d   = timeBcd_q;
        lapBcd_d    = lapBcd_q;
        lapStrobe_d = 1'b0;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        mode_d      = mode_q;
        if (stop_i) begin
            state_d   = IDLE;
            presc_d   = '0;
            timeBcd_d = '0;
            lapBcd_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        timeBcd_d = presetClamped;
                    end else if (playRise && !(down_i && timeBcd_q == 36'd0)) begin
                        mode_d  = down_i;
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (lap_i) begin
                        lapBcd_d    = timeBcd_q;
                        lapStrobe_d = 1'b1;
                    end
                    if (playRise) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (mode_q) begin
                            timeBcd_d = timeDec;
                            if (decZero) begin
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            timeBcd_d = timeInc;
                            wrap_d    = incWrap;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (lap_i) begin
                        lapBcd_d    = timeBcd_q;
                        lapStrobe_d = 1'b1;
                    end
                    if (playRise) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    // State and output registers; running follows the next state so it
    // changes on the same edge as the state itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            timeBcd_q   <= '0;
            lapBcd_q    <= '0;
            lapStrobe_q <= 1'b0;
            running_q   <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            playPrev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            timeBcd_q   <= timeBcd_d;
            lapBcd_q    <= lapBcd_d;
            lapStrobe_q <= lapStrobe_d;
            running_q   <= (state_d == RUN);
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            mode_q      <= mode_d;
            playPrev_q  <= play_i;
        end
    end

    assign time_bcd_o   = timeBcd_q;
    assign lap_bcd_o    = lapBcd_q;
    assign lap_strobe_o = lapStrobe_q;
    assign running_o    = running_q;
    assign wrap_o       = wrap_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_cronometro_bcd_param.sv
// tb_cronometro_bcd_param
//
// Drives two stopwatch instances with identical stimulus: one with
// HOUR_MAX=99 and one with HOUR_MAX=1, both using DIV=4. The reference
// model keeps the time as an integer millisecond count and converts it
// to BCD only for comparison.

module tb_cronometro_bcd_param;

    localparam int DIV     = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        lap = 1'b0;
    logic        load = 1'b0;
    logic        down = 1'b0;
    logic [35:0] preset = '0;

    logic [35:0] timeA, lapA, timeB, lapB;
    logic        strobeA, runA, wrapA, doneA;
    logic        strobeB, runB, wrapB, doneB;

    int total = 0;
    int bad   = 0;

    int mState[2] = '{0, 0};
    int mPresc[2] = '{0, 0};
    int mTime[2]  = '{0, 0};
    int mLapT[2]  = '{0, 0};
    bit mStrobe[2] = '{0, 0};
    bit mWrap[2]   = '{0, 0};
    bit mDone[2]   = '{0, 0};
    bit mMode[2]   = '{0, 0};
    bit mPrev      = 1'b0;

    always #5 clk = ~clk;

    cronometro_bcd_param #(.DIV(DIV), .HOUR_MAX(99)) dutA (
        .clk_i(clk), .rst_i(rst), .play_i(play), .stop_i(stop), .lap_i(lap),
        .load_i(load), .down_i(down), .preset_bcd_i(preset),
        .time_bcd_o(timeA), .lap_bcd_o(lapA), .lap_strobe_o(strobeA),
        .running_o(runA), .wrap_o(wrapA), .done_o(doneA)
    );

    cronometro_bcd_param #(.DIV(DIV), .HOUR_MAX(1)) dutB (
        .clk_i(clk), .rst_i(rst), .play_i(play), .stop_i(stop), .lap_i(lap),
        .load_i(load), .down_i(down), .preset_bcd_i(preset),
        .time_bcd_o(timeB), .lap_bcd_o(lapB), .lap_strobe_o(strobeB),
        .running_o(runB), .wrap_o(wrapB), .done_o(doneB)
    );

    wire [75:0] obsA = {timeA, lapA, strobeA, runA, wrapA, doneA};
    wire [75:0] obsB = {timeB, lapB, strobeB, runB, wrapB, doneB};

    function automatic int hourMaxOf(input int k);
        return (k == 0) ? 99 : 1;
    endfunction

    function automatic int maxMs(input int k);
        return (hourMaxOf(k) + 1) * 3600000 - 1;
    endfunction

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [35:0] msToBcd(input int ms);
        int h, mn, s, f;
        h  = ms / 3600000;
        mn = (ms / 60000) % 60;
        s  = (ms / 1000) % 60;
        f  = ms % 1000;
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10), 4'(s / 10),
                4'(s % 10), 4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
    endfunction

    function automatic int presetToMs(input logic [35:0] p, input int k);
        int f, s, mn, h;
        f  = lim(int'(p[3:0]), 9) + 10 * lim(int'(p[7:4]), 9) + 100 * lim(int'(p[11:8]), 9);
        s  = lim(int'(p[15:12]), 9) + 10 * lim(int'(p[19:16]), 5);
        mn = lim(int'(p[23:20]), 9) + 10 * lim(int'(p[27:24]), 5);
        h  = lim(int'(p[31:28]), 9) + 10 * lim(int'(p[35:32]), 9);
        h  = lim(h, hourMaxOf(k));
        return ((h * 60 + mn) * 60 + s) * 1000 + f;
    endfunction

    function automatic logic [75:0] expOut(input int k);
        return {msToBcd(mTime[k]), msToBcd(mLapT[k]), mStrobe[k],
                mState[k] == S_RUN, mWrap[k], mDone[k]};
    endfunction

    function automatic logic [75:0] obsOf(input int k);
        return (k == 0) ? obsA : obsB;
    endfunction

    // Behavioural reference: one call per rising clock edge, using the
    // input values that the DUTs sampled on that edge.
    task automatic modelStep();
        bit rise;
        rise = play && !mPrev;
        for (int k = 0; k < 2; k++) begin
            mStrobe[k] = 1'b0;
            mWrap[k]   = 1'b0;
            mDone[k]   = 1'b0;
            if (rst) begin
                mState[k] = S_IDLE; mTime[k] = 0; mLapT[k] = 0;
                mPresc[k] = 0; mMode[k] = 1'b0;
            end else if (stop) begin
                mState[k] = S_IDLE; mTime[k] = 0; mLapT[k] = 0; mPresc[k] = 0;
            end else begin
                case (mState[k])
                    S_IDLE: begin
                        if (load) begin
                            mTime[k] = presetToMs(preset, k);
                        end else if (rise && !(down && mTime[k] == 0)) begin
                            mMode[k] = down; mState[k] = S_RUN; mPresc[k] = 0;
                        end
                    end
                    S_RUN: begin
                        if (lap) begin
                            mLapT[k] = mTime[k]; mStrobe[k] = 1'b1;
                        end
                        if (rise) begin
                            mState[k] = S_PAUSE;
                        end else if (mPresc[k] == DIV - 1) begin
                            mPresc[k] = 0;
                            if (mMode[k]) begin
                                mTime[k] = mTime[k] - 1;
                                if (mTime[k] == 0) begin
                                    mDone[k] = 1'b1; mState[k] = S_DONE;
                                end
                            end else if (mTime[k] == maxMs(k)) begin
                                mTime[k] = 0; mWrap[k] = 1'b1;
                            end else begin
                                mTime[k] = mTime[k] + 1;
                            end
                        end else begin
                            mPresc[k] = mPresc[k] + 1;
                        end
                    end
                    S_PAUSE: begin
                        if (lap) begin
                            mLapT[k] = mTime[k]; mStrobe[k] = 1'b1;
                        end
                        if (rise) mState[k] = S_RUN;
                    end
                    default: ;
                endcase
            end
        end
        mPrev = rst ? 1'b0 : play;
    endtask

    // One clock edge: inputs stay stable around the rising edge, the model
    // steps right after it, and control returns at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsOf(k) !== 76'd0) begin
                bad++;
                $display("[TB] FAIL reset dut%0d: got %h want 0", k, obsOf(k));
            end
        end
    endtask

    task automatic test_count_up();
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsOf(k) !== expOut(k)) begin
                    bad++;
                    $display("[TB] FAIL count_up dut%0d cyc%0d: got %h want %h", k, c, obsOf(k), expOut(k));
                end
            end
        end
        total++;
        if (timeA !== 36'h000000010 || runA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL count_up_final: got time %h run %b want 000000010 1", timeA, runA);
        end
    endtask

    task automatic test_pause_resume();
        int          held;
        int          found;
        logic [35:0] snap;
        int          waitCycles;
        waitCycles = $urandom_range(1, 7);
        for (int c = 0; c < waitCycles; c++) applyStimulus();
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        held = mPresc[0];
        snap = msToBcd(mTime[0]);
        total++;
        if (runA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pause_running: got %b want 0", runA);
        end
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            total++;
            if (timeA !== snap) begin
                bad++;
                $display("[TB] FAIL pause_hold cyc%0d: got %h want %h", c, timeA, snap);
            end
        end
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        found = 0;
        for (int i = 1; i <= 8 && found == 0; i++) begin
            applyStimulus();
            if (timeA !== snap) found = i;
        end
        total++;
        if (found != DIV - held) begin
            bad++;
            $display("[TB] FAIL resume_latency: got %0d edges want %0d", found, DIV - held);
        end
        total++;
        if (timeA !== msToBcd(mTime[0])) begin
            bad++;
            $display("[TB] FAIL resume_value: got %h want %h", timeA, msToBcd(mTime[0]));
        end
    endtask

    task automatic test_wrap();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        load = 1'b1; preset = 36'h015959999;
        applyStimulus();
        load = 1'b0; down = 1'b0; play = 1'b1;
        applyStimulus();
        play = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus();
        total++;
        if (timeB !== 36'd0 || wrapB !== 1'b1 || runB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrap_hm1: got time %h wrap %b run %b want 0 1 1", timeB, wrapB, runB);
        end
        total++;
        if (timeA !== 36'h020000000 || wrapA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL carry_hm99: got time %h wrap %b want 020000000 0", timeA, wrapA);
        end
        applyStimulus();
        total++;
        if (wrapB !== 1'b0 || timeB !== 36'd0) begin
            bad++;
            $display("[TB] FAIL wrap_pulse_len: got wrap %b time %h want 0 0", wrapB, timeB);
        end
    endtask

    task automatic test_clamp();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        load = 1'b1; preset = 36'h99F9F9999;
        applyStimulus();
        total++;
        if (timeB !== 36'h015959999 || timeA !== 36'h995959999) begin
            bad++;
            $display("[TB] FAIL clamp_fixed: got %h %h want 015959999 995959999", timeB, timeA);
        end
        for (int i = 0; i < 6; i++) begin
            preset = {4'($urandom), 32'($urandom)};
            applyStimulus();
            total++;
            if (timeA !== msToBcd(presetToMs(preset, 0)) || timeB !== msToBcd(presetToMs(preset, 1))) begin
                bad++;
                $display("[TB] FAIL clamp_random preset %h: got %h %h want %h %h", preset, timeA, timeB,
                         msToBcd(presetToMs(preset, 0)), msToBcd(presetToMs(preset, 1)));
            end
        end
        load = 1'b0;
    endtask

    task automatic test_countdown();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        load = 1'b1; preset = 36'h000000002;
        applyStimulus();
        load = 1'b0; down = 1'b1; play = 1'b1;
        applyStimulus();
        play = 1'b0; down = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus();
        total++;
        if (timeA !== 36'd1 || runA !== 1'b1 || doneA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL countdown_1: got time %h run %b done %b want 1 1 0", timeA, runA, doneA);
        end
        for (int c = 0; c < 4; c++) applyStimulus();
        total++;
        if (timeA !== 36'd0 || runA !== 1'b0 || doneA !== 1'b1 || doneB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL countdown_0: got time %h run %b done %b/%b want 0 0 1/1", timeA, runA, doneA, doneB);
        end
        applyStimulus();
        total++;
        if (doneA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_pulse_len: got %b want 0", doneA);
        end
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        applyStimulus();
        total++;
        if (runA !== 1'b0 || timeA !== 36'd0 || doneA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_ignores_play: got run %b time %h done %b want 0 0 0", runA, timeA, doneA);
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        total++;
        if (runA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_after_done: got run %b want 1", runA);
        end
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
    endtask

    task automatic test_lap();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0; play = 1'b1;
        applyStimulus();
        play = 1'b0;
        for (int c = 0; c < 39; c++) applyStimulus();
        lap = 1'b1;
        applyStimulus();
        lap = 1'b0;
        total++;
        if (lapA !== 36'h000000009 || strobeA !== 1'b1 || timeA !== 36'h000000010) begin
            bad++;
            $display("[TB] FAIL lap_capture: got lap %h strobe %b time %h want 9 1 10", lapA, strobeA, timeA);
        end
        applyStimulus();
        total++;
        if (strobeA !== 1'b0 || lapA !== 36'h000000009) begin
            bad++;
            $display("[TB] FAIL lap_strobe_len: got strobe %b lap %h want 0 9", strobeA, lapA);
        end
    endtask

    task automatic test_simultaneous();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0; play = 1'b1;
        applyStimulus();
        play = 1'b0;
        for (int c = 0; c < 6; c++) applyStimulus();
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        applyStimulus();
        applyStimulus();
        stop = 1'b1; play = 1'b1;
        applyStimulus();
        stop = 1'b0; play = 1'b0;
        total++;
        if (timeA !== 36'd0 || runA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_beats_play: got time %h run %b want 0 0", timeA, runA);
        end
        play = 1'b1;
        applyStimulus();
        play = 1'b0;
        lap = 1'b1;
        for (int c = 0; c < 10; c++) applyStimulus();
        lap = 1'b0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsOf(k) !== 76'd0) begin
                bad++;
                $display("[TB] FAIL reset_mid_run dut%0d: got %h want 0", k, obsOf(k));
            end
        end
        down = 1'b1; play = 1'b1;
        applyStimulus();
        play = 1'b0;
        for (int c = 0; c < 8; c++) applyStimulus();
        total++;
        if (runA !== 1'b0 || timeA !== 36'd0 || doneA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL down_zero_start: got run %b time %h done %b want 0 0 0", runA, timeA, doneA);
        end
        down = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) play = ~play;
            lap  = ($urandom_range(0, 5) == 0);
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) down = ~down;
            case ($urandom_range(0, 3))
                0: preset = {4'($urandom), 32'($urandom)};
                1: preset = 36'($urandom_range(0, 5));
                2: preset = 36'h015959997;
                default: preset = 36'h995959998;
            endcase
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsOf(k) !== expOut(k)) begin
                    bad++;
                    $display("[TB] FAIL random dut%0d cyc%0d: got %h want %h", k, c, obsOf(k), expOut(k));
                end
            end
        end
        rst = 1'b0; stop = 1'b0; play = 1'b0; lap = 1'b0; load = 1'b0; down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_pause_resume();
        test_wrap();
        test_clamp();
        test_countdown();
        test_lap();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
